telemetry_packetizer: RTL and testbench

Serializes one telemetry sample (four 16-bit fields) into an 8-byte little-endian packet and presents it byte by byte on a FIFO-style read interface that drives the UART transmitter's `data_in` / `fifo_empty` / `fifo_read` ports. It is the sending-side counterpart of the receive-side byte reassembly that feeds `scoring_model`. A one-deep shadow buffer lets the next sample be accepted while the current packet drains, so back-to-back packets go out without a bubble.

---
 rtl/telemetry_pkg.sv | 18 +
 rtl/telemetry_packetizer.sv | 115 +++++++++++
 tb/tb_telemetry_packetizer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_pkg.sv
// Shared telemetry types: packed sample layout (byte i = bits [8i+7:8i]) and packetizer FSM encodings.
package telemetry_pkg;
  localparam int PACKET_BYTES = 8;
  localparam int FIELD_W      = 16;
  localparam int IDX_W        = $clog2(PACKET_BYTES);

  typedef struct packed {
    logic [FIELD_W-1:0] temp;
    logic [FIELD_W-1:0] mem;
    logic [FIELD_W-1:0] disk;
    logic [FIELD_W-1:0] cpu;
  } telemetry_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
endpackage

// File: rtl/telemetry_packetizer.sv
// Serializes one telemetry sample into an 8-byte little-endian packet behind a FIFO-style read port,
// with a one-deep shadow slot so consecutive packets stream without a bubble.
module telemetry_packetizer
  import telemetry_pkg::*;
#(
  parameter int INTER_PACKET_GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [15:0]  cpu_freq_mhz,
  input  logic [15:0]  disk_speed_mbps,
  input  logic [15:0]  memory_usage,
  input  logic [15:0]  temperature_c,
  output logic         sample_ready,
  output logic [7:0]   data_out,
  output logic         fifo_empty,
  input  logic         fifo_read,
  output logic         packet_done,
  output logic         overrun,
  input  logic         clear_overrun
);
  localparam int GW = (INTER_PACKET_GAP > 1) ? $clog2(INTER_PACKET_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((INTER_PACKET_GAP > 0) ? INTER_PACKET_GAP - 1 : 0);

  state_t           state;
  telemetry_t       active, pending, sample;
  logic [IDX_W-1:0] idx;
  logic             pending_valid;
  logic [GW-1:0]    gap_cnt;
  logic             accept, consume, last_read;

  assign sample       = {temperature_c, memory_usage, disk_speed_mbps, cpu_freq_mhz};
  assign sample_ready = !pending_valid;
  assign accept       = sample_valid && sample_ready;
  assign consume      = fifo_read && (state == ST_SEND);
  assign last_read    = consume && (idx == IDX_W'(PACKET_BYTES - 1));

  // Output mux depends only on registered state; fifo_read never reaches data_out.
  assign fifo_empty = (state != ST_SEND);
  assign data_out   = fifo_empty ? 8'h00 : active[{idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      idx           <= '0;
      gap_cnt       <= '0;
      packet_done   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      packet_done <= last_read;

      if (sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clear_overrun)            overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            active <= sample;
            idx    <= '0;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (consume) idx <= idx + IDX_W'(1);
          if (last_read) begin
            idx <= '0;
            if (INTER_PACKET_GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
              if (accept) begin
                pending       <= sample;
                pending_valid <= 1'b1;
              end
            end else if (pending_valid) begin
              active        <= pending;
              pending_valid <= 1'b0;
            end else if (accept) begin
              active <= sample;
            end else begin
              state <= ST_IDLE;
            end
          end else if (accept) begin
            pending       <= sample;
            pending_valid <= 1'b1;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GAP_LAST) begin
            idx <= '0;
            if (pending_valid) begin
              active        <= pending;
              pending_valid <= 1'b0;
              state         <= ST_SEND;
            end else if (accept) begin
              // Arrives on the gap's final cycle: go straight to active so it cannot strand in pending.
              active <= sample;
              state  <= ST_SEND;
            end else begin
              state <= ST_IDLE;
            end
          end else if (accept) begin
            pending       <= sample;
            pending_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_telemetry_packetizer.sv
// Directed and randomized checks of telemetry_packetizer against a byte-queue reference model.
module tb_telemetry_packetizer;
  typedef logic [7:0] pkt_t [8];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sv0, rd0, clr0, sr0, fe0, pd0, ov0;
  logic [15:0] cpu0, dsk0, mem0, tmp0;
  logic [7:0]  do0;
  logic        sv5, rd5, clr5, sr5, fe5, pd5, ov5;
  logic [15:0] cpu5, dsk5, mem5, tmp5;
  logic [7:0]  do5;

  int checks = 0;
  int errors = 0;

  telemetry_packetizer #(.INTER_PACKET_GAP(0)) u0 (
    .clk(clk), .rst(rst), .sample_valid(sv0),
    .cpu_freq_mhz(cpu0), .disk_speed_mbps(dsk0), .memory_usage(mem0), .temperature_c(tmp0),
    .sample_ready(sr0), .data_out(do0), .fifo_empty(fe0), .fifo_read(rd0),
    .packet_done(pd0), .overrun(ov0), .clear_overrun(clr0));

  telemetry_packetizer #(.INTER_PACKET_GAP(5)) u5 (
    .clk(clk), .rst(rst), .sample_valid(sv5),
    .cpu_freq_mhz(cpu5), .disk_speed_mbps(dsk5), .memory_usage(mem5), .temperature_c(tmp5),
    .sample_ready(sr5), .data_out(do5), .fifo_empty(fe5), .fifo_read(rd5),
    .packet_done(pd5), .overrun(ov5), .clear_overrun(clr5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Packet bytes from field values: low byte then high byte, fields in cpu/disk/mem/temp order.
  function automatic pkt_t mk(input logic [15:0] c, input logic [15:0] d,
                              input logic [15:0] m, input logic [15:0] t);
    pkt_t r;
    logic [15:0] f [4];
    f = '{c, d, m, t};
    for (int k = 0; k < 4; k++) begin
      r[2*k]   = 8'(f[k] % 16'd256);
      r[2*k+1] = 8'(f[k] / 16'd256);
    end
    return r;
  endfunction

  task automatic set0(input logic [15:0] c, input logic [15:0] d,
                      input logic [15:0] m, input logic [15:0] t);
    cpu0 = c; dsk0 = d; mem0 = m; tmp0 = t;
  endtask

  task automatic send0(input logic [15:0] c, input logic [15:0] d,
                       input logic [15:0] m, input logic [15:0] t);
    set0(c, d, m, t);
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
  endtask

  task automatic read0(input pkt_t p, input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("%s empty b%0d", tag, i), fe0, 0);
      chk($sformatf("%s byte b%0d", tag, i), do0, p[i]);
      rd0 = 1'b1;
      tick();
    end
    rd0 = 1'b0;
  endtask

  initial begin
    logic [15:0] a [4];
    logic [15:0] b [4];
    logic [15:0] c [4];
    logic [7:0]  lit [8];
    pkt_t pa, pb, pz;
    int cnt;
    logic [7:0] act_q [$];
    logic [7:0] pend_q [$];
    bit pend_v, m_ov, m_done;

    rst = 1'b1;
    {sv0, rd0, clr0, sv5, rd5, clr5} = '0;
    set0(0, 0, 0, 0);
    {cpu5, dsk5, mem5, tmp5} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst fifo_empty", fe0, 1);
    chk("rst data_out", do0, 8'h00);
    chk("rst sample_ready", sr0, 1);
    chk("rst packet_done", pd0, 0);
    chk("rst overrun", ov0, 0);

    // Known-value packet, plus fifo_read held high in IDLE must not disturb anything
    rd0 = 1'b1;
    repeat (3) tick();
    chk("idle read empty", fe0, 1);
    rd0 = 1'b0;
    lit = '{8'h94, 8'h11, 8'hD0, 8'h07, 8'h00, 8'h40, 8'h46, 8'h00};
    send0(4500, 2000, 16384, 70);
    read0(lit, 0, 7, "known");
    chk("known done pulse", pd0, 1);
    tick();
    chk("known done low", pd0, 0);
    chk("known idle empty", fe0, 1);

    // Back-to-back: second sample arrives at byte 3, no bubble between packets
    foreach (a[k]) a[k] = 16'($urandom);
    b = '{16'd3400, 16'($urandom), 16'($urandom), 16'($urandom)};
    pa = mk(a[0], a[1], a[2], a[3]);
    pb = mk(b[0], b[1], b[2], b[3]);
    send0(a[0], a[1], a[2], a[3]);
    read0(pa, 0, 2, "b2b A");
    chk("b2b A byte3", do0, pa[3]);
    set0(b[0], b[1], b[2], b[3]);
    sv0 = 1'b1; rd0 = 1'b1;
    tick();
    sv0 = 1'b0;
    chk("b2b ready low", sr0, 0);
    read0(pa, 4, 7, "b2b A");
    chk("b2b next byte0", do0, 8'h48);
    chk("b2b no bubble", fe0, 0);
    chk("b2b ready back", sr0, 1);
    chk("b2b done A", pd0, 1);
    read0(pb, 0, 7, "b2b B");
    chk("b2b done B", pd0, 1);
    tick();
    chk("b2b idle", fe0, 1);

    // Overrun: third sample while pending full is dropped
    foreach (a[k]) a[k] = 16'($urandom);
    foreach (b[k]) b[k] = 16'($urandom);
    foreach (c[k]) c[k] = ~b[k];
    pa = mk(a[0], a[1], a[2], a[3]);
    pb = mk(b[0], b[1], b[2], b[3]);
    send0(a[0], a[1], a[2], a[3]);
    send0(b[0], b[1], b[2], b[3]);
    chk("ovr pre", ov0, 0);
    send0(c[0], c[1], c[2], c[3]);
    chk("ovr set", ov0, 1);
    read0(pa, 0, 7, "ovr A");
    read0(pb, 0, 7, "ovr B");
    tick();
    chk("ovr drained", fe0, 1);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("ovr cleared", ov0, 0);

    // Set wins over a simultaneous clear; drop on last-byte with pending full
    send0(a[0], a[1], a[2], a[3]);
    send0(b[0], b[1], b[2], b[3]);
    set0(c[0], c[1], c[2], c[3]);
    sv0 = 1'b1; clr0 = 1'b1;
    tick();
    sv0 = 1'b0; clr0 = 1'b0;
    chk("ovr set wins", ov0, 1);
    read0(pa, 0, 6, "last A");
    chk("last A byte7", do0, pa[7]);
    sv0 = 1'b1; rd0 = 1'b1;
    tick();
    sv0 = 1'b0; rd0 = 1'b0;
    chk("last pending moved", do0, pb[0]);
    chk("last ready", sr0, 1);
    chk("last ovr", ov0, 1);
    read0(pb, 0, 7, "last B");
    tick();
    chk("last drained", fe0, 1);
    clr0 = 1'b1; tick(); clr0 = 1'b0;

    // Gap of 5 with a pending sample; fifo_read held high through the gap
    foreach (a[k]) a[k] = 16'($urandom);
    foreach (b[k]) b[k] = 16'($urandom);
    pa = mk(a[0], a[1], a[2], a[3]);
    pb = mk(b[0], b[1], b[2], b[3]);
    {cpu5, dsk5, mem5, tmp5} = {a[0], a[1], a[2], a[3]};
    sv5 = 1'b1; tick();
    {cpu5, dsk5, mem5, tmp5} = {b[0], b[1], b[2], b[3]};
    tick(); sv5 = 1'b0;
    chk("gap pending", sr5, 0);
    rd5 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("gap A byte b%0d", i), do5, pa[i]);
      tick();
    end
    cnt = 0;
    while (fe5 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("gap length", cnt, 5);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("gap B byte b%0d", i), do5, pb[i]);
      tick();
    end
    rd5 = 1'b0;
    chk("gap done B", pd5, 1);

    // Reset mid-packet with pending full and overrun set
    send0(a[0], a[1], a[2], a[3]);
    send0(b[0], b[1], b[2], b[3]);
    send0(b[0], b[1], b[2], b[3]);
    read0(pa, 0, 4, "mid");
    chk("mid ovr", ov0, 1);
    rst = 1'b1;
    #1;
    chk("mid rst empty", fe0, 1);
    chk("mid rst data", do0, 8'h00);
    chk("mid rst ready", sr0, 1);
    chk("mid rst done", pd0, 0);
    chk("mid rst ovr", ov0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post rst empty", fe0, 1);
    pz = mk(16'd0, 16'd0, 16'd0, 16'd255);
    send0(0, 0, 0, 255);
    chk("restart byte0", do0, 8'h00);
    read0(pz, 0, 5, "restart");
    chk("restart byte6", do0, 8'hFF);
    read0(pz, 6, 7, "restart");
    chk("restart done", pd0, 1);

    // Randomized run against a queue model (gap 0)
    rst = 1'b1; #1; @(negedge clk); rst = 1'b0; tick();
    act_q = {}; pend_q = {}; pend_v = 0; m_ov = 0; m_done = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit idle, rdy, acc, cons, last, sv, rd, clr;
      pkt_t p;
      chk("rnd empty", fe0, act_q.size() == 0);
      chk("rnd data", do0, (act_q.size() == 0) ? 8'h00 : act_q[0]);
      chk("rnd ready", sr0, !pend_v);
      chk("rnd done", pd0, m_done);
      chk("rnd ovr", ov0, m_ov);
      sv  = ($urandom_range(3) == 0);
      rd  = ($urandom_range(3) != 0);
      clr = ($urandom_range(15) == 0);
      foreach (c[k]) c[k] = 16'($urandom);
      set0(c[0], c[1], c[2], c[3]);
      sv0 = sv; rd0 = rd; clr0 = clr;
      idle = (act_q.size() == 0);
      rdy  = !pend_v;
      acc  = sv && rdy;
      cons = rd && !idle;
      last = cons && (act_q.size() == 1);
      if (sv && !rdy) m_ov = 1;
      else if (clr)   m_ov = 0;
      m_done = last;
      if (cons) void'(act_q.pop_front());
      p = mk(c[0], c[1], c[2], c[3]);
      if (last && pend_v) begin
        act_q = pend_q;
        pend_v = 0;
      end else if (acc) begin
        if (idle || last) begin
          act_q = {};
          foreach (p[k]) act_q.push_back(p[k]);
        end else begin
          pend_q = {};
          foreach (p[k]) pend_q.push_back(p[k]);
          pend_v = 1;
        end
      end
      tick();
    end
    {sv0, rd0, clr0} = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
